mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-memory port, downstream of the single-cycle core.
- Consumes the core's MemWrite / Mem_WrAddr / Mem_WrData.
- Supplies read data for its status register; top-level muxes it into the core's ReadData when mmio_sel is high.
- Bytes written to TXDATA are queued in a FIFO and serialised 8N1, LSB first, on tx.

Parameters:
- BASE_ADDR, 32'h0000_4000, word-aligned base of the 3-word register window.
- CLK_DIV, 16, clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..256.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  store strobe from core.
- Mem_WrAddr  in  32  load/store address from core.
- Mem_WrData  in  32  store data from core.
- mmio_sel  out  1  combinational; high when Mem_WrAddr[31:4] == BASE_ADDR[31:4] and Mem_WrAddr[3:2] != 2'b11.
- mmio_rdata  out  32  combinational read data.
- tx  out  1  serial output, idle high.
- tx_irq  out  1  registered; high while FIFO empty and serialiser idle.

Behaviour:
- Register map. Offsets are decoded on Mem_WrAddr[3:2]; bits [1:0] are ignored.
  - +0x0 TXDATA (write only): Mem_WrData[7:0] is pushed into the FIFO; upper bits are ignored.
  - +0x4 STATUS (read/write):
    - bit0 full, bit1 empty, bit2 busy (state != IDLE), bit3 overflow (sticky), bits[31:4] = 0.
    - Writing with Mem_WrData[3]=1 clears overflow; all other bits are read-only.
  - +0x8 COUNT (read only): FIFO occupancy in bits[8:0], zero-extended.
  - Reads of TXDATA, and of any address with mmio_sel low, return 0.
- Read data is purely combinational from Mem_WrAddr and current state. Zero-cycle read latency, as the single-cycle core requires.
- Push:
  - Occurs when MemWrite & mmio_sel & offset==0 at a rising edge.
  - If the FIFO is full at that edge, the byte is dropped and overflow is set. This holds even if the serialiser pops in the same cycle.
  - Push and pop in the same cycle with FIFO not full: occupancy is unchanged and both take effect.
- Serialiser FSM: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is non-empty, pop the head into shift_reg, clear bit_cnt, load baud_cnt=CLK_DIV-1, go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA.
  - DATA: tx=shift_reg[0] for CLK_DIV cycles per bit, shifting right after each bit. After 8 bits go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - baud_cnt counts down; a bit ends on the cycle baud_cnt==0.
- Latency: a TXDATA write at edge N with the FIFO empty and the FSM in IDLE → pop at edge N+1 → tx falls after edge N+1. Frame length is exactly 10*CLK_DIV cycles.
- tx is registered (driven from flops), so it is glitch-free.
- Reset: the following take effect at the next rising edge.
  - FIFO emptied, overflow=0, state=IDLE, tx=1, tx_irq=1, counters cleared.
  - Reset mid-frame aborts the frame immediately; tx returns high. Any partial byte is lost.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The occupancy counter is log2(FIFO_DEPTH)+1 bits, which distinguishes full from empty.

Optional Feature:
- UART_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP.
  - The parity state drives the even parity of the 8 data bits for CLK_DIV cycles.
  - Frame length becomes 11*CLK_DIV.
  - STATUS bit4 reads 1 to advertise parity.
- UART_PARITY_EN undefined: no PARITY state, 10-bit frames, STATUS bit4 reads 0.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE/START/DATA/STOP/PARITY);
  - register offset constants OFF_TXDATA=2'd0, OFF_STATUS=2'd1, OFF_COUNT=2'd2;
  - STATUS bit-position constants.
- One sub-module, sync_fifo: parameterised width/depth with push/pop, full/empty, count, synchronous reset.
- Decode, registers and FSM stay in mmio_uart_tx.

Test Plan:
- Reset defaults: assert reset 2 cycles → tx=1, tx_irq=1, STATUS read = 0x2, COUNT read = 0.
- Single frame (CLK_DIV=4): write 0x55 to BASE+0 → tx falls one edge later. Bits sampled mid-bit read 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop). tx_irq returns to 1 after 40 cycles.
- Back-to-back: write 0xA5 then 0x3C on consecutive cycles → two contiguous 40-cycle frames with no idle gap. COUNT reads 1 during the first frame.
- Overflow (FIFO_DEPTH=8): write 10 bytes in 10 consecutive cycles → 9 accepted (1 popped + 8 queued), 1 dropped. STATUS reads full=1 and overflow=1. Writing 0x8 to BASE+4 clears overflow; exactly 9 frames are emitted.
- Reset mid-frame: reset during DATA bit 3 → next cycle tx=1, state IDLE, COUNT=0, and no further frames.
- Decode: write to BASE+0xC and BASE+0x10 → mmio_sel=0, FIFO unchanged, mmio_rdata=0. With UART_PARITY_EN, writing 0x07 gives parity bit 1 and frames of 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter:
// serialiser state encoding, register offsets and STATUS bit positions.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;

   localparam int ST_FULL   = 0;
   localparam int ST_EMPTY  = 1;
   localparam int ST_BUSY   = 2;
   localparam int ST_OVF    = 3;
   localparam int ST_PARITY = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally. Storage is not reset, only pointers and count.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA/STATUS/COUNT window, TX FIFO, 8N1 serialiser.
// Define UART_PARITY_EN to insert an even-parity bit (11-bit frames).
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low) for CLK_DIV cycles
// DATA   | 8 data bits, LSB first
// PARITY | even parity of the byte (UART_PARITY_EN only)
// STOP   | stop bit (high); pops the next byte directly into START
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_4000,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] Mem_WrAddr,
   input  logic [31:0] Mem_WrData,
   output logic        mmio_sel,
   output logic [31:0] mmio_rdata,
   output logic        tx,
   output logic        tx_irq
);

   localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

   uart_state_e state, state_nxt;
   logic [7:0]  shift_reg, shift_nxt;
   logic [2:0]  bit_cnt, bit_cnt_nxt;
   logic [15:0] baud_cnt, baud_nxt;
   logic        tx_nxt;
   logic        overflow;
`ifdef UART_PARITY_EN
   logic        parity_reg, parity_nxt;
`endif

   logic [1:0]    offset;
   logic          wr_txdata;
   logic          wr_status;
   logic          push_ok;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic          empty_nxt;
   logic [7:0]    fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic [31:0]   status;
   logic          baud_done;
   logic          unused_bits;

   assign offset      = Mem_WrAddr[3:2];
   assign mmio_sel    = (Mem_WrAddr[31:4] == BASE_ADDR[31:4]) && (offset != 2'b11);
   assign wr_txdata   = MemWrite & mmio_sel & (offset == OFF_TXDATA);
   assign wr_status   = MemWrite & mmio_sel & (offset == OFF_STATUS);
   assign push_ok     = wr_txdata & ~fifo_full;
   assign baud_done   = (baud_cnt == '0);
   assign unused_bits = ^{Mem_WrAddr[1:0], Mem_WrData[31:8]};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txdata),
      .pop   (fifo_pop),
      .wdata (Mem_WrData[7:0]),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Post-edge emptiness, so tx_irq is registered yet not a cycle late.
   assign empty_nxt = !push_ok &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && fifo_pop));

   always_comb begin
      status            = '0;
      status[ST_FULL]   = fifo_full;
      status[ST_EMPTY]  = fifo_empty;
      status[ST_BUSY]   = (state != IDLE);
      status[ST_OVF]    = overflow;
`ifdef UART_PARITY_EN
      status[ST_PARITY] = 1'b1;
`endif
   end

   always_comb begin
      mmio_rdata = '0;
      if (mmio_sel) begin
         case (offset)
            OFF_STATUS: mmio_rdata = status;
            OFF_COUNT:  mmio_rdata = 32'(fifo_count);
            default:    mmio_rdata = '0;
         endcase
      end
   end

   always_comb begin
      state_nxt   = state;
      shift_nxt   = shift_reg;
      bit_cnt_nxt = bit_cnt;
      baud_nxt    = baud_cnt;
      fifo_pop    = 1'b0;
`ifdef UART_PARITY_EN
      parity_nxt  = parity_reg;
`endif
      case (state)
         IDLE: begin
            fifo_pop = ~fifo_empty;
         end
         START: begin
            baud_nxt = baud_done ? BAUD_RELOAD : baud_cnt - 16'd1;
            if (baud_done) state_nxt = DATA;
         end
         DATA: begin
            baud_nxt = baud_done ? BAUD_RELOAD : baud_cnt - 16'd1;
            if (baud_done) begin
               shift_nxt = {1'b0, shift_reg[7:1]};
               if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end
            end
         end
         PARITY: begin
            baud_nxt = baud_done ? BAUD_RELOAD : baud_cnt - 16'd1;
            if (baud_done) state_nxt = STOP;
         end
         STOP: begin
            baud_nxt = baud_done ? BAUD_RELOAD : baud_cnt - 16'd1;
            if (baud_done) begin
               fifo_pop  = ~fifo_empty;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (fifo_pop) begin
         shift_nxt   = fifo_rdata;
         bit_cnt_nxt = '0;
         baud_nxt    = BAUD_RELOAD;
         state_nxt   = START;
`ifdef UART_PARITY_EN
         parity_nxt  = ^fifo_rdata;
`endif
      end

      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_PARITY_EN
         PARITY:  tx_nxt = parity_nxt;
`endif
         default: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         baud_cnt   <= '0;
         tx         <= 1'b1;
         tx_irq     <= 1'b1;
         overflow   <= 1'b0;
`ifdef UART_PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         shift_reg  <= shift_nxt;
         bit_cnt    <= bit_cnt_nxt;
         baud_cnt   <= baud_nxt;
         tx         <= tx_nxt;
         tx_irq     <= (state_nxt == IDLE) && empty_nxt;
`ifdef UART_PARITY_EN
         parity_reg <= parity_nxt;
`endif
         // A byte dropped on a full FIFO flags overflow even if a pop coincides.
         if (wr_txdata && fifo_full)
            overflow <= 1'b1;
         else if (wr_status && Mem_WrData[ST_OVF])
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a timing-level model queues expected
// frames (byte + start cycle); a line monitor decodes tx and compares.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE  = 32'h0000_4000;
   localparam int          D     = 4;
   localparam int          DEPTH = 8;
`ifdef UART_PARITY_EN
   localparam int          NBITS   = 11;
   localparam logic [31:0] PAR_BIT = 32'h10;
`else
   localparam int          NBITS   = 10;
   localparam logic [31:0] PAR_BIT = 32'h0;
`endif
   localparam int FRAME = NBITS * D;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_write = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        mmio_sel;
   logic [31:0] mmio_rdata;
   logic        tx;
   logic        tx_irq;

   mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (rst),
      .MemWrite   (mem_write),
      .Mem_WrAddr (addr),
      .Mem_WrData (wdata),
      .mmio_sel   (mmio_sel),
      .mmio_rdata (mmio_rdata),
      .tx         (tx),
      .tx_irq     (tx_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] mq[$];
   int         frame_left = 0;
   int         cyc = 0;
   int         last_pop = 0;
   bit         ovf = 1'b0;
   bit         model_valid = 1'b0;

   int checks = 0;
   int failures = 0;
   int frames_seen = 0;

   bit          mon_active = 1'b0;
   int          mon_cnt = 0;
   int          mon_start = 0;
   logic [10:0] mon_bits = '0;

   function automatic bit dec_sel(logic [31:0] a);
      return (a[31:4] == BASE[31:4]) && (a[3:2] != 2'b11);
   endfunction

   function automatic logic [10:0] exp_frame(logic [7:0] b);
      logic [10:0] v;
      v      = '0;
      v[8:1] = b;
`ifdef UART_PARITY_EN
      v[9]   = ^b;
      v[10]  = 1'b1;
`else
      v[9]   = 1'b1;
`endif
      return v;
   endfunction

   function automatic logic [31:0] exp_rdata(logic [31:0] a);
      logic [31:0] s;
      if (!dec_sel(a)) return 32'h0;
      case (a[3:2])
         2'd1: begin
            s = PAR_BIT;
            if (mq.size() == DEPTH) s = s | 32'h1;
            if (mq.size() == 0)     s = s | 32'h2;
            if (frame_left > 0)     s = s | 32'h4;
            if (ovf)                s = s | 32'h8;
            return s;
         end
         2'd2:    return 32'(mq.size());
         default: return 32'h0;
      endcase
   endfunction

   // Reference model: a byte queue plus a frame timer.
   always @(posedge clk) begin : model
      bit   full_b;
      bit   hit_tx;
      exp_t e;
      cyc = cyc + 1;
      if (rst) begin
         mq.delete();
         exp_q.delete();
         frame_left  = 0;
         ovf         = 1'b0;
         model_valid = 1'b1;
      end else begin
         full_b = (mq.size() == DEPTH);
         hit_tx = mem_write && dec_sel(addr) && (addr[3:2] == 2'd0);
         if (frame_left > 0) frame_left = frame_left - 1;
         if (frame_left == 0 && mq.size() > 0) begin
            e.data = mq.pop_front();
            e.cyc  = cyc;
            exp_q.push_back(e);
            frame_left = FRAME;
            last_pop   = cyc;
         end
         if (hit_tx) begin
            if (full_b) ovf = 1'b1;
            else        mq.push_back(wdata[7:0]);
         end
         if (mem_write && dec_sel(addr) && addr[3:2] == 2'd1 && wdata[3]) ovf = 1'b0;
      end
   end

   // Line monitor: decodes frames mid-bit and checks idle line / irq each cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst) begin
         mon_active = 1'b0;
      end else if (model_valid) begin
         if (!mon_active && tx === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            mon_bits   = '0;
            mon_start  = cyc;
         end
         if (mon_active) begin
            if (mon_cnt % D == D / 2) mon_bits[mon_cnt / D] = tx;
            if (mon_cnt == FRAME - 1) begin
               mon_active  = 1'b0;
               frames_seen = frames_seen + 1;
               checks      = checks + 1;
               if (exp_q.size() == 0) begin
                  failures = failures + 1;
                  $display("FAIL frame_unexpected: got bits=%b start=%0d, none expected", mon_bits, mon_start);
               end else begin
                  e = exp_q.pop_front();
                  if (mon_bits !== exp_frame(e.data) || mon_start != e.cyc) begin
                     failures = failures + 1;
                     $display("FAIL frame: got bits=%b start=%0d, expected bits=%b start=%0d",
                              mon_bits, mon_start, exp_frame(e.data), e.cyc);
                  end
               end
            end
            mon_cnt = mon_cnt + 1;
         end
         checks = checks + 1;
         if (tx_irq !== (frame_left == 0 && mq.size() == 0)) begin
            failures = failures + 1;
            $display("FAIL tx_irq @%0d: got=%b expected=%b", cyc, tx_irq, (frame_left == 0 && mq.size() == 0));
         end
         if (frame_left == 0) begin
            checks = checks + 1;
            if (tx !== 1'b1) begin
               failures = failures + 1;
               $display("FAIL idle_line @%0d: got tx=%b expected 1", cyc, tx);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      step();
      mem_write = 1'b1;
      addr      = a;
      wdata     = d;
   endtask

   task automatic bus_idle();
      step();
      mem_write = 1'b0;
      addr      = 32'h0;
      wdata     = 32'h0;
   endtask

   task automatic read_check(input logic [31:0] a, input string name);
      step();
      mem_write = 1'b0;
      addr      = a;
      #1;
      check({name, "_sel"}, {31'b0, mmio_sel}, {31'b0, dec_sel(a)});
      check(name, mmio_rdata, exp_rdata(a));
   endtask

   task automatic wait_idle(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && mq.size() == 0 && frame_left == 0 && !mon_active) begin
            done = 1'b1;
            break;
         end
         step();
      end
      checks = checks + 1;
      if (!done) begin
         failures = failures + 1;
         $display("FAIL idle_timeout: got pending=%0d expected 0 within %0d cycles", exp_q.size() + mq.size(), budget);
      end
   endtask

   initial begin
      #(100000 * 10);
      $display("FAIL watchdog: simulation did not finish, got cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int          f0;
      int unsigned r;

      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("reset_tx", {31'b0, tx}, 32'h1);
      check("reset_irq", {31'b0, tx_irq}, 32'h1);
      read_check(BASE + 32'h4, "reset_status");
      check("reset_status_const", mmio_rdata, 32'h2 | PAR_BIT);
      read_check(BASE + 32'h8, "reset_count");
      check("reset_count_const", mmio_rdata, 32'h0);

      // Single frame: tx falls one edge after the write edge.
      f0 = frames_seen;
      bus_write(BASE, 32'hFFFF_FF55);
      step();
      mem_write = 1'b0;
      check("tx_before_pop", {31'b0, tx}, 32'h1);
      step();
      check("tx_start_bit", {31'b0, tx}, 32'h0);
      wait_idle(FRAME + 20);
      check("single_frames", 32'(frames_seen - f0), 32'd1);

      // Back-to-back frames, low address bits ignored.
      f0 = frames_seen;
      bus_write(BASE, 32'hA5);
      bus_write(BASE | 32'h2, 32'h3C);
      read_check(BASE + 32'h8, "count_b2b");
      check("count_b2b_const", mmio_rdata, 32'h1);
      wait_idle(2 * FRAME + 20);
      check("b2b_frames", 32'(frames_seen - f0), 32'd2);

      // Overflow: 10 writes, 9 accepted.
      f0 = frames_seen;
      for (int i = 0; i < 10; i++) bus_write(BASE, 32'h10 + 32'(i));
      read_check(BASE + 32'h4, "ovf_status");
      check("ovf_status_const", mmio_rdata, 32'hD | PAR_BIT);
      bus_write(BASE + 32'h4, 32'h8);
      read_check(BASE + 32'h4, "ovf_cleared");
      check("ovf_cleared_const", mmio_rdata, 32'h5 | PAR_BIT);
      wait_idle(10 * FRAME + 50);
      check("ovf_frames", 32'(frames_seen - f0), 32'd9);

      // Decode: out-of-window writes do nothing and read zero.
      step();
      mem_write = 1'b1;
      addr      = BASE + 32'hC;
      wdata     = 32'h77;
      #1;
      check("sel_off_c", {31'b0, mmio_sel}, 32'h0);
      check("rdata_off_c", mmio_rdata, 32'h0);
      step();
      addr = BASE + 32'h10;
      #1;
      check("sel_off_10", {31'b0, mmio_sel}, 32'h0);
      check("rdata_off_10", mmio_rdata, 32'h0);
      read_check(BASE + 32'h8, "decode_count");
      check("decode_count_const", mmio_rdata, 32'h0);
      read_check(BASE, "txdata_read");

`ifdef UART_PARITY_EN
      f0 = frames_seen;
      bus_write(BASE, 32'h07);
      bus_write(BASE, 32'h07);
      bus_idle();
      wait_idle(2 * FRAME + 20);
      check("parity_frames", 32'(frames_seen - f0), 32'd2);
`endif

      // Randomized traffic across the window and outside it.
      for (int i = 0; i < 120; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3, 4: bus_write(BASE | ($urandom & 32'h3), $urandom);
            5:             bus_write(BASE + 32'hC + ($urandom & 32'h3), $urandom);
            6:             bus_write(BASE + 32'h10, $urandom);
            7:             bus_write(BASE + 32'h4, $urandom);
            8:             read_check(BASE + (32'($urandom_range(0, 3)) << 2), "rand_read");
            default:       bus_idle();
         endcase
      end
      bus_idle();
      wait_idle((DEPTH + 2) * FRAME + 100);

      // Reset during data bit 3 aborts the frame and flushes the FIFO.
      bus_write(BASE, 32'h96);
      bus_write(BASE, 32'h11);
      bus_idle();
      for (int i = 0; i < 200 && (cyc - last_pop) < 4 * D + 1; i++) step();
      rst = 1'b1;
      f0  = frames_seen;
      step();
      check("midreset_tx", {31'b0, tx}, 32'h1);
      read_check(BASE + 32'h8, "midreset_count");
      check("midreset_count_const", mmio_rdata, 32'h0);
      read_check(BASE + 32'h4, "midreset_status");
      check("midreset_status_const", mmio_rdata, 32'h2 | PAR_BIT);
      rst = 1'b0;
      repeat (3 * FRAME) step();
      check("midreset_no_frames", 32'(frames_seen - f0), 32'd0);
      check("midreset_tx_idle", {31'b0, tx}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
